qsys_sys_clk_timer_driver: RTL and testbench
============================================

# qsys_sys_clk_timer_driver

Hardware Avalon-MM master that drives the system clock timer's 16-bit register slave without CPU involvement. It programs the period, starts the timer in continuous mode with interrupts enabled, services each timeout by clearing the status register, and maintains a 32-bit tick count for fabric logic. It sits beside the timer in the Qsys system and connects point-to-point to the timer's s1 slave and irq line.

## Interface
- `TICK_W`, 32: width of `tick_count`.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset; deasserted synchronously to `clk`.
- `cfg_period` in 32: raw period register value; the timer times out every `cfg_period`+1 cycles. Sampled when `cfg_start` is accepted.
- `cfg_start` in 1: single-cycle request to program and start the timer.
- `cfg_stop` in 1: single-cycle request to stop the timer.
- `busy` out 1: high whenever the state is not IDLE.
- `tick_pulse` out 1: one-cycle pulse per serviced timeout.
- `tick_count` out `TICK_W`: serviced-timeout count; wraps modulo 2^`TICK_W`.
- `snap_value` out 32: last captured counter snapshot (only with `TIMER_DRIVER_SNAPSHOT_EN`).
- `snap_valid` out 1: one-cycle pulse when `snap_value` updates (only with `TIMER_DRIVER_SNAPSHOT_EN`).
- `m_address` out 3, `m_chipselect` out 1, `m_write_n` out 1, `m_writedata` out 16: master command to the timer slave.
- `m_readdata` in 16: slave read data, registered one cycle after the address.
- `timer_irq` in 1: timer interrupt; level-sensitive, cleared by a status write.

## Operation
- Register map: 0 status, 1 control, 2 period_l, 3 period_h, 4 snap_l, 5 snap_h.
- Control bits: [0] ITO, [1] CONT, [2] START, [3] STOP.
- All master outputs are registered and decoded from the state.
- Idle bus state: `m_chipselect`=0, `m_write_n`=1, `m_address`=0, `m_writedata`=0.
- States and transitions:
  - IDLE: on `cfg_start`, latch `cfg_period` and go to WR_PL. `cfg_stop` is ignored.
  - WR_PL: write address 2 with period[15:0], then go to WR_PH.
  - WR_PH: write address 3 with period[31:16], then go to WR_CTRL.
  - WR_CTRL: write address 1 with 0x0007, then go to RUN.
  - RUN: if `cfg_stop` or `stop_pending`, go to WR_STOP. Otherwise, if `timer_irq`, go to CLR_ST.
  - CLR_ST: write address 0 with 0x0000. `tick_count` increments by 1 and `tick_pulse`=1 in this cycle. Next state is SNAP_WR when snapshot is enabled and not stopping, IDLE when stopping, otherwise RUN.
  - WR_STOP: write address 1 with 0x0008, then go to CLR_ST in stopping mode. This CLR_ST does not increment `tick_count` and does not pulse `tick_pulse`; it then goes to IDLE.
  - SNAP_WR: write address 4.
  - SNAP_RL: read address 4 (`m_chipselect`=1, `m_write_n`=1).
  - SNAP_RH: read address 5; capture `m_readdata` into `snap_value`[15:0].
  - SNAP_CAP: idle bus; capture `m_readdata` into `snap_value`[31:16]; pulse `snap_valid`; go to RUN, or to WR_STOP if `stop_pending`.
- `stop_pending` is set by `cfg_stop` in any non-IDLE state other than RUN, and is cleared on entering WR_STOP.
- `cfg_start` outside IDLE is ignored.
- When `cfg_stop` and `timer_irq` are both high in RUN, stop wins. The pending status is still cleared by the stopping CLR_ST, and no tick is counted.
- A timeout that lands in the same cycle as a status write is lost; the slave gives the clear priority. This is accepted behaviour.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `tick_pulse`, `snap_valid` = 0.
  - `tick_count` = 0, `snap_value` = 0.
  - Bus outputs at idle values.
  - `stop_pending` = 0.
- `cfg_start` sampled at edge T: WR_PL occupies cycle T+1, WR_PH T+2, WR_CTRL T+3, and RUN is entered at T+4. `busy` rises at T+1.
- `timer_irq` seen in RUN at edge E: the CLR_ST write occurs in cycle E+1, and `timer_irq` is low from E+2.
- Service latency is 2 cycles without snapshot and 5 cycles with snapshot. The minimum supported `cfg_period` is 5 with snapshot and 2 without.
- Reset asserted mid-sequence returns the bus to idle values immediately. The timer itself is not stopped; the timer shares `reset_n`.

## Configuration
- `TIMER_DRIVER_SNAPSHOT_EN` defined: the SNAP_* states, `snap_value` and `snap_valid` exist, and every serviced timeout is followed by a snapshot capture.
- Not defined: CLR_ST returns directly to RUN, `snap_value` is tied to 0, and `snap_valid` is tied to 0.

## Test plan
- Reset, then `cfg_start` with `cfg_period`=0x0001_86A0 → three writes in consecutive cycles: addr2/0x86A0, addr3/0x0001, addr1/0x0007. `busy` is high from the cycle after start.
- `cfg_period`=9 run for 100 cycles after RUN → `timer_irq` every 10 cycles, `tick_count`=10 (±1 for window phase), and exactly one status write per tick.
- `cfg_stop` in RUN → addr1/0x0008 write, then addr0 write, then IDLE. `tick_count` is unchanged and `timer_irq` stays 0 afterwards.
- `cfg_stop` and `timer_irq` high in the same RUN cycle → stop path taken, no `tick_pulse`, and irq cleared. Separately, `cfg_stop` during WR_PH → full config completes, then the stop sequence runs.
- `reset_n` low during WR_PH → bus idle immediately, all outputs at reset values, and a later `cfg_start` reprograms correctly.
- With `TIMER_DRIVER_SNAPSHOT_EN` and `cfg_period`=20 → after each tick, the addr4 write and addr4/5 reads occur, `snap_valid` pulses, and `snap_value` equals the slave counter value at the snap write edge.

Source files
------------

// File: rtl/qsys_sys_clk_timer_driver.sv
// Avalon-MM master that programs, runs and services the system clock timer and keeps a tick count.
// Optional counter snapshot after every serviced timeout: define TIMER_DRIVER_SNAPSHOT_EN.
module qsys_sys_clk_timer_driver #(
  parameter int TICK_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  output logic              busy,
  output logic              tick_pulse,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snap_value,
  output logic              snap_valid,
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              timer_irq
);

  localparam logic [2:0]  ADDR_STATUS = 3'd0;
  localparam logic [2:0]  ADDR_CTRL   = 3'd1;
  localparam logic [2:0]  ADDR_PER_L  = 3'd2;
  localparam logic [2:0]  ADDR_PER_H  = 3'd3;
  localparam logic [2:0]  ADDR_SNAP_L = 3'd4;
  localparam logic [2:0]  ADDR_SNAP_H = 3'd5;
  localparam logic [15:0] CTRL_RUN    = 16'h0007;  // ITO | CONT | START
  localparam logic [15:0] CTRL_STOP   = 16'h0008;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_CLR_ST, S_WR_STOP,
    S_SNAP_WR, S_SNAP_RL, S_SNAP_RH, S_SNAP_CAP
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         period_q, period_d;
  logic                stop_pending_q, stop_pending_d;
  logic                stopping_q, stopping_d;

  logic                busy_q, busy_d;
  logic                tick_pulse_q, tick_pulse_d;
  logic [TICK_W-1:0]   tick_count_q, tick_count_d;
  logic [2:0]          addr_q, addr_d;
  logic                cs_q, cs_d;
  logic                wr_n_q, wr_n_d;
  logic [15:0]         wdata_q, wdata_d;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      period_q       <= '0;
      stop_pending_q <= 1'b0;
      stopping_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      period_q       <= period_d;
      stop_pending_q <= stop_pending_d;
      stopping_q     <= stopping_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    period_d       = period_q;
    stop_pending_d = stop_pending_q;
    stopping_d     = stopping_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          period_d = cfg_period;
          state_d  = S_WR_PL;
        end
      end
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_RUN;
      S_RUN: begin
        if (cfg_stop || stop_pending_q) state_d = S_WR_STOP;
        else if (timer_irq)             state_d = S_CLR_ST;
      end
      S_CLR_ST: begin
        if (stopping_q) state_d = S_IDLE;
        else begin
`ifdef TIMER_DRIVER_SNAPSHOT_EN
          state_d = S_SNAP_WR;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_WR_STOP: state_d = S_CLR_ST;
`ifdef TIMER_DRIVER_SNAPSHOT_EN
      S_SNAP_WR:  state_d = S_SNAP_RL;
      S_SNAP_RL:  state_d = S_SNAP_RH;
      S_SNAP_RH:  state_d = S_SNAP_CAP;
      S_SNAP_CAP: state_d = stop_pending_q ? S_WR_STOP : S_RUN;
`endif
      default:   state_d = S_IDLE;
    endcase

    // A stop arriving mid-sequence is deferred until the sequence reaches a safe point.
    if (cfg_stop && state_q != S_IDLE && state_q != S_RUN) stop_pending_d = 1'b1;
    if (state_d == S_WR_STOP || state_d == S_IDLE)         stop_pending_d = 1'b0;

    if (state_d == S_WR_STOP)   stopping_d = 1'b1;
    else if (state_d == S_IDLE) stopping_d = 1'b0;
  end

  // Output decode from the upcoming state so every master output is a flop
  always_comb begin
    busy_d       = (state_d != S_IDLE);
    tick_pulse_d = (state_d == S_CLR_ST) && !stopping_d;
    tick_count_d = tick_pulse_d ? tick_count_q + TICK_W'(1) : tick_count_q;
    cs_d         = 1'b0;
    wr_n_d       = 1'b1;
    addr_d       = 3'd0;
    wdata_d      = 16'h0000;
    case (state_d)
      S_WR_PL:   begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_PER_L;  wdata_d = period_d[15:0];  end
      S_WR_PH:   begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_PER_H;  wdata_d = period_d[31:16]; end
      S_WR_CTRL: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_CTRL;   wdata_d = CTRL_RUN;        end
      S_CLR_ST:  begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_STATUS;                            end
      S_WR_STOP: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_CTRL;   wdata_d = CTRL_STOP;       end
      S_SNAP_WR: begin cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_SNAP_L;                            end
      S_SNAP_RL: begin cs_d = 1'b1;                addr_d = ADDR_SNAP_L;                            end
      S_SNAP_RH: begin cs_d = 1'b1;                addr_d = ADDR_SNAP_H;                            end
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q       <= 1'b0;
      tick_pulse_q <= 1'b0;
      tick_count_q <= '0;
      cs_q         <= 1'b0;
      wr_n_q       <= 1'b1;
      addr_q       <= 3'd0;
      wdata_q      <= 16'h0000;
    end else begin
      busy_q       <= busy_d;
      tick_pulse_q <= tick_pulse_d;
      tick_count_q <= tick_count_d;
      cs_q         <= cs_d;
      wr_n_q       <= wr_n_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

`ifdef TIMER_DRIVER_SNAPSHOT_EN
  logic [31:0] snap_value_q;
  logic        snap_valid_q;

  // Read data lags the address by one cycle, so each half is taken in the following state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      if (state_q == S_SNAP_RH)  snap_value_q[15:0]  <= m_readdata;
      if (state_q == S_SNAP_CAP) snap_value_q[31:16] <= m_readdata;
      snap_valid_q <= (state_q == S_SNAP_CAP);
    end
  end

  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^m_readdata;
  assign snap_value      = 32'h0;
  assign snap_valid      = 1'b0;
`endif

  assign busy         = busy_q;
  assign tick_pulse   = tick_pulse_q;
  assign tick_count   = tick_count_q;
  assign m_address    = addr_q;
  assign m_chipselect = cs_q;
  assign m_write_n    = wr_n_q;
  assign m_writedata  = wdata_q;

endmodule

// File: tb/tb_qsys_sys_clk_timer_driver.sv
// Scoreboard bench: a behavioural timer slave model predicts bus traffic, ticks and snapshots.
module tb_qsys_sys_clk_timer_driver;

`ifdef TIMER_DRIVER_SNAPSHOT_EN
  localparam int MINP  = 5;
  localparam int SVC_N = 4;
`else
  localparam int MINP  = 2;
  localparam int SVC_N = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic [31:0] cfg_period;
  logic        cfg_start, cfg_stop;
  logic        busy, tick_pulse, snap_valid;
  logic [31:0] tick_count, snap_value;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [15:0] m_writedata, m_readdata;
  logic        timer_irq;

  qsys_sys_clk_timer_driver #(.TICK_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_start(cfg_start),
    .cfg_stop(cfg_stop), .busy(busy), .tick_pulse(tick_pulse), .tick_count(tick_count),
    .snap_value(snap_value), .snap_valid(snap_valid), .m_address(m_address),
    .m_chipselect(m_chipselect), .m_write_n(m_write_n), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [2:0] addr; logic [15:0] data; } bus_t;
  bus_t        exp_bus[$];
  logic [31:0] exp_tick[$];
  logic [31:0] exp_snap[$];
  logic [31:0] tick_model;
  bit          svc_en;
  int          n_err, n_checks;

  // Timer slave model
  logic [31:0] t_period, t_count, t_snap;
  logic        t_run, t_ito, t_to, t_timeout;
  assign t_timeout = t_run && (t_count == 32'd0);
  assign timer_irq = t_to & t_ito;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_service();
    tick_model = tick_model + 1;
    exp_tick.push_back(tick_model);
    exp_bus.push_back('{1'b1, 3'd0, 16'h0000});
`ifdef TIMER_DRIVER_SNAPSHOT_EN
    exp_bus.push_back('{1'b1, 3'd4, 16'h0000});
    exp_bus.push_back('{1'b0, 3'd4, 16'h0000});
    exp_bus.push_back('{1'b0, 3'd5, 16'h0000});
`endif
  endtask

  task automatic push_stop();
    exp_bus.push_back('{1'b1, 3'd1, 16'h0008});
    exp_bus.push_back('{1'b1, 3'd0, 16'h0000});
  endtask

  task automatic finish_stop();
    int quiet_hits;
    @(negedge clk);
    cfg_stop = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("stop_idle", {31'd0, busy}, 32'd0);
    check("tick_after_stop", tick_count, tick_model);
    check("bus_drained", exp_bus.size(), 32'd0);
    quiet_hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (timer_irq) quiet_hits++;
    end
    check("irq_quiet", quiet_hits, 32'd0);
    check("status_cleared", {31'd0, t_to}, 32'd0);
  endtask

  // mode 0: normal start, 1: stop during WR_PH, 2: reset during WR_PH
  task automatic do_start(input logic [31:0] p, input int mode);
    @(negedge clk);
    check("busy_before_start", {31'd0, busy}, 32'd0);
    exp_bus.push_back('{1'b1, 3'd2, p[15:0]});
    exp_bus.push_back('{1'b1, 3'd3, p[31:16]});
    exp_bus.push_back('{1'b1, 3'd1, 16'h0007});
    cfg_period = p;
    cfg_start  = 1'b1;
    svc_en     = 1'b1;
    @(posedge clk);
    #1;
    check("busy_rise", {31'd0, busy}, 32'd1);
    @(negedge clk);
    cfg_start  = 1'b0;
    cfg_period = $urandom;
    @(negedge clk);
    if (mode == 1) begin
      cfg_stop = 1'b1;
      svc_en   = 1'b0;
      push_stop();
      finish_stop();
    end else if (mode == 2) begin
      reset_n = 1'b0;
      #1;
      check("rst_bus_idle", {11'd0, m_chipselect, m_write_n, m_address, m_writedata},
            {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_tick_count", tick_count, 32'd0);
      check("rst_snap_value", snap_value, 32'd0);
      exp_bus.delete();
      exp_tick.delete();
      exp_snap.delete();
      tick_model = 0;
      svc_en     = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
    end
  endtask

  task automatic do_stop(input bit collide);
    bit prev, found;
    found = 1'b0;
    if (collide) begin
      prev = timer_irq;
      for (int k = 0; k < 400 && !found; k++) begin
        @(negedge clk);
        if (timer_irq && !prev) found = 1'b1;
        else prev = timer_irq;
      end
      if (!found) begin
        n_checks++;
        n_err++;
        $display("FAIL collide_wait: got no irq rise expected one within 400 cycles");
      end
    end
    if (!found) begin
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (!timer_irq) break;
      end
    end
    cfg_stop = 1'b1;
    svc_en   = 1'b0;
    if (found) begin
      // Stop beats the simultaneous timeout: that service is never performed.
      for (int i = 0; i < SVC_N; i++) void'(exp_bus.pop_back());
      void'(exp_tick.pop_back());
      tick_model = tick_model - 1;
    end
    $display("stop issued collide=%0d", found);
    push_stop();
    finish_stop();
  endtask

  initial begin
    logic [31:0] c0, p;
    reset_n = 1'b0; cfg_period = '0; cfg_start = 1'b0; cfg_stop = 1'b0;
    svc_en = 1'b0; tick_model = '0; n_err = 0; n_checks = 0;
    fork
      begin : timer_model
        forever begin
          @(posedge clk or negedge reset_n);
          if (!reset_n) begin
            t_period <= '0; t_count <= '0; t_snap <= '0;
            t_run <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0; m_readdata <= '0;
          end else begin
            if (t_run) t_count <= t_timeout ? t_period : t_count - 32'd1;
            if (m_chipselect && !m_write_n) begin
              case (m_address)
                3'd1: begin
                  t_ito <= m_writedata[0];
                  if (m_writedata[2]) t_run <= 1'b1;
                  if (m_writedata[3]) t_run <= 1'b0;
                end
                3'd2: begin
                  t_period[15:0] <= m_writedata;
                  t_count <= {t_period[31:16], m_writedata};
                  t_run <= 1'b0;
                end
                3'd3: begin
                  t_period[31:16] <= m_writedata;
                  t_count <= {m_writedata, t_period[15:0]};
                  t_run <= 1'b0;
                end
                3'd4, 3'd5: begin
                  t_snap <= t_count;
                  exp_snap.push_back(t_count);
                end
                default: ;
              endcase
            end
            if (m_chipselect && !m_write_n && m_address == 3'd0) t_to <= 1'b0;
            else if (t_timeout) begin
              t_to <= 1'b1;
              if (svc_en) push_service();
            end
            if (m_chipselect && m_write_n) begin
              case (m_address)
                3'd0:    m_readdata <= {14'd0, t_run, t_to};
                3'd4:    m_readdata <= t_snap[15:0];
                3'd5:    m_readdata <= t_snap[31:16];
                default: m_readdata <= 16'h0000;
              endcase
            end
          end
        end
      end
      begin : monitor
        bus_t        e;
        logic [31:0] v;
        forever begin
          @(negedge clk);
          if (reset_n) begin
            if (m_chipselect) begin
              $display("bus %s addr=%0d data=0x%04h", m_write_n ? "rd" : "wr", m_address, m_writedata);
              if (exp_bus.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL bus_unexpected: got addr=%0d wr=%0d expected no access", m_address, !m_write_n);
              end else begin
                e = exp_bus.pop_front();
                check("bus_txn", {12'd0, !m_write_n, m_address, m_write_n ? 16'h0 : m_writedata},
                      {12'd0, e.wr, e.addr, e.wr ? e.data : 16'h0});
              end
            end
            if (tick_pulse) begin
              $display("tick count=%0d", tick_count);
              if (exp_tick.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL tick_unexpected: got pulse count=%0d expected none", tick_count);
              end else begin
                v = exp_tick.pop_front();
                check("tick_count", tick_count, v);
              end
            end
            if (snap_valid) begin
              $display("snap value=0x%08h", snap_value);
              if (exp_snap.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL snap_unexpected: got 0x%0h expected none", snap_value);
              end else begin
                v = exp_snap.pop_front();
                check("snap_value", snap_value, v);
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_tick_pulse", {31'd0, tick_pulse}, 32'd0);
    check("reset_tick_count", tick_count, 32'd0);
    check("reset_snap", {snap_value[30:0], snap_valid}, 32'd0);
    check("reset_bus", {11'd0, m_chipselect, m_write_n, m_address, m_writedata},
          {11'd0, 1'b0, 1'b1, 3'd0, 16'h0000});
    reset_n = 1'b1;

    do_start(32'h0001_86A0, 0);
    repeat (20) @(negedge clk);
    do_stop(1'b0);

    do_start(32'd9, 0);
    repeat (2) @(negedge clk);
    c0 = tick_count;
    repeat (100) @(negedge clk);
    c0 = tick_count - c0;
    check("tick_rate_9", {31'd0, (c0 >= 32'd9 && c0 <= 32'd11)}, 32'd1);
    do_stop(1'b0);

    do_start(MINP + 3, 0);
    repeat (5) @(negedge clk);
    do_stop(1'b1);

    do_start(32'd12, 1);

    do_start(32'd12, 2);
    do_start(32'd20, 0);
    repeat (80) @(negedge clk);
    do_stop(1'b0);

    for (int it = 0; it < 8; it++) begin
      p = $urandom_range(30, MINP);
      $display("random run %0d period=%0d", it, p);
      do_start(p, 0);
      repeat ($urandom_range(120, 10)) @(negedge clk);
      do_stop(1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
